// File: rtl/glb_buf_writer_if.sv
// Stream-in / buffer-write bundle of the global-buffer writer.
// GLB_BUF_WRITER_WMASK_EN adds the per-lane write mask buf_wmask.
interface glb_buf_writer_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_COL     = 8,
  parameter int BUFFER_SIZE = 512
);
  localparam int AW = $clog2(BUFFER_SIZE);
  localparam int NW = $clog2(BUFFER_SIZE * NUM_COL) + 1;

  logic                          start;
  logic [AW-1:0]                 base_addr;
  logic [NW-1:0]                 num_words;
  logic                          in_valid;
  logic [DATA_WIDTH-1:0]         in_data;
  logic                          in_ready;
  logic                          buf_wen;
  logic [AW-1:0]                 buf_addr;
  logic [NUM_COL*DATA_WIDTH-1:0] buf_wdata;
  logic                          busy;
  logic                          done;
`ifdef GLB_BUF_WRITER_WMASK_EN
  logic [NUM_COL-1:0]            buf_wmask;

  modport master (
    output start, base_addr, num_words, in_valid, in_data,
    input  in_ready, buf_wen, buf_addr, buf_wdata, busy, done, buf_wmask
  );
  modport slave (
    input  start, base_addr, num_words, in_valid, in_data,
    output in_ready, buf_wen, buf_addr, buf_wdata, busy, done, buf_wmask
  );
`else
  modport master (
    output start, base_addr, num_words, in_valid, in_data,
    input  in_ready, buf_wen, buf_addr, buf_wdata, busy, done
  );
  modport slave (
    input  start, base_addr, num_words, in_valid, in_data,
    output in_ready, buf_wen, buf_addr, buf_wdata, busy, done
  );
`endif
endinterface

// File: rtl/glb_buf_writer.sv
// Global-buffer write engine: packs NUM_COL stream words per line, writes lines at consecutive addresses.
// Optional macro GLB_BUF_WRITER_WMASK_EN drives buf_wmask (lanes holding stream words).
module glb_buf_writer #(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_COL     = 8,
  parameter int BUFFER_SIZE = 512
) (
  input  logic            clk,
  input  logic            rst,
  glb_buf_writer_if.slave bus
);
  localparam int AW = $clog2(BUFFER_SIZE);
  localparam int NW = $clog2(BUFFER_SIZE * NUM_COL) + 1;
  localparam int CW = (NUM_COL > 1) ? $clog2(NUM_COL) : 1;
  localparam int LW = NUM_COL * DATA_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t          state_q;
  logic [AW-1:0]   addr_q;
  logic [NW-1:0]   rem_q;
  logic [CW-1:0]   col_q;
  logic [LW-1:0]   line_q;
  logic            in_ready_q;
  logic            buf_wen_q;
  logic [AW-1:0]   buf_addr_q;
  logic [LW-1:0]   buf_wdata_q;
  logic            busy_q;
  logic            done_q;

  logic            hs_s;
  logic            close_s;
  logic [LW-1:0]   line_d;

  assign hs_s    = bus.in_valid & in_ready_q;
  assign close_s = hs_s & ((col_q == CW'(NUM_COL - 1)) | (rem_q == NW'(1'b1)));

  // Line register with the incoming word merged into lane col_q.
  always_comb begin
    line_d = line_q;
    for (int k = 0; k < NUM_COL; k++) begin
      if (CW'(k) == col_q) begin
        line_d[k*DATA_WIDTH +: DATA_WIDTH] = bus.in_data;
      end else begin
        line_d[k*DATA_WIDTH +: DATA_WIDTH] = line_q[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

`ifdef GLB_BUF_WRITER_WMASK_EN
  logic [NUM_COL-1:0] wmask_q;
  logic [NUM_COL-1:0] wmask_d;

  // Lanes 0..col_q are occupied once the closing word lands.
  always_comb begin
    wmask_d = '0;
    for (int k = 0; k < NUM_COL; k++) begin
      if (CW'(k) <= col_q) begin
        wmask_d[k] = 1'b1;
      end else begin
        wmask_d[k] = 1'b0;
      end
    end
  end

  // Mask is captured together with the line it describes.
  always_ff @(posedge clk) begin
    if (rst) begin
      wmask_q <= '0;
    end else if (state_q == ST_FILL && close_s) begin
      wmask_q <= wmask_d;
    end else begin
      wmask_q <= wmask_q;
    end
  end

  assign bus.buf_wmask = wmask_q;
`endif

  // Job sequencer: IDLE -> FILL <-> WRITE -> DONE, all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      col_q       <= '0;
      line_q      <= '0;
      in_ready_q  <= 1'b0;
      buf_wen_q   <= 1'b0;
      buf_addr_q  <= '0;
      buf_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          buf_wen_q <= 1'b0;
          done_q    <= 1'b0;
          if (bus.start) begin
            if (bus.num_words != '0) begin
              addr_q     <= bus.base_addr;
              rem_q      <= bus.num_words;
              col_q      <= '0;
              line_q     <= '0;
              busy_q     <= 1'b1;
              in_ready_q <= 1'b1;
              state_q    <= ST_FILL;
            end else begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end
          end
        end
        ST_FILL: begin
          if (hs_s) begin
            rem_q  <= rem_q - NW'(1'b1);
            col_q  <= col_q + CW'(1'b1);
            line_q <= line_d;
            if (close_s) begin
              in_ready_q  <= 1'b0;
              buf_wen_q   <= 1'b1;
              buf_addr_q  <= addr_q;
              buf_wdata_q <= line_d;
              state_q     <= ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          buf_wen_q <= 1'b0;
          // Address width equals log2(BUFFER_SIZE), so the increment wraps naturally.
          addr_q    <= addr_q + AW'(1'b1);
          col_q     <= '0;
          line_q    <= '0;
          if (rem_q != '0) begin
            in_ready_q <= 1'b1;
            state_q    <= ST_FILL;
          end else begin
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q    <= ST_IDLE;
          in_ready_q <= 1'b0;
          buf_wen_q  <= 1'b0;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.buf_wen   = buf_wen_q;
  assign bus.buf_addr  = buf_addr_q;
  assign bus.buf_wdata = buf_wdata_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
endmodule
